cnn_seq_ctrl: RTL and testbench

CNN_SEQ_CTRL -- requirements
Module: cnn_seq_ctrl

---
 rtl/cnn_seq_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_cnn_seq_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_seq_ctrl.sv
// Layer/stage sequencer for a CNN datapath. Walks the enabled stages of a
// latched stage mask in ascending order, repeats that walk once per layer,
// and guards every stage with an optional watchdog.
//
// Stage handshake: the controller issues a one-cycle stage_en[i] pulse.
// The stage reports completion by raising the level stage_done[i]. The
// controller accepts that completion only on a later cycle in which
// stage_en[i] is low and i is the current stage. A stale done that is still
// high from an earlier pass is therefore never taken in the pulse cycle.
// done bits of other stages are ignored.
module cnn_seq_ctrl #(
   parameter int NUM_STAGES = 4,
   parameter int LAYER_W    = 4,
   parameter int TMO_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  abort,
   input  logic [NUM_STAGES-1:0] mode,
   input  logic [LAYER_W-1:0]    num_layers,
   input  logic [TMO_W-1:0]      tmo_limit,
   input  logic [NUM_STAGES-1:0] stage_done,
   output logic [NUM_STAGES-1:0] stage_en,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [2:0]            cur_stage,
   output logic [LAYER_W-1:0]    layer_idx
);

   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

   state_t                state_q, state_d;
   logic [NUM_STAGES-1:0] mode_q, mode_d;
   logic [LAYER_W-1:0]    nl_q, nl_d;
   logic [TMO_W-1:0]      tmo_q, tmo_d;
   logic [NUM_STAGES-1:0] stage_en_q, stage_en_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [2:0]            cur_q, cur_d;
   logic [LAYER_W-1:0]    layer_q, layer_d;
   logic [TMO_W-1:0]      wd_q, wd_d;

   // Stage vectors widened to 8 bits so a 3-bit stage index selects cleanly.
   logic [7:0]         mode_in8, mode_q8, done8, en8;
   logic [2:0]         low_in, low_q;
   logic [3:0]         next_q;
   logic               accept;
   logic [LAYER_W:0]   layer_inc;
   logic               more_layers;
   logic [TMO_W-1:0]   wd_inc;

   // Index of the lowest set bit (0 when the mask is empty).
   function automatic logic [2:0] lowest_bit(input logic [7:0] m);
      logic [2:0] r;
      r = '0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) r = 3'(i);
      end
      return r;
   endfunction

   // {found, index} of the lowest set bit strictly above cur.
   function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] cur);
      logic [3:0] r;
      r = '0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i] && (i > int'(cur))) r = {1'b1, 3'(i)};
      end
      return r;
   endfunction

   assign mode_in8    = 8'(mode);
   assign mode_q8     = 8'(mode_q);
   assign done8       = 8'(stage_done);
   assign en8         = 8'(stage_en_q);
   assign low_in      = lowest_bit(mode_in8);
   assign low_q       = lowest_bit(mode_q8);
   assign next_q      = next_above(mode_q8, cur_q);
   assign accept      = (state_q == ST_WAIT) && !en8[cur_q] && done8[cur_q];
   assign layer_inc   = {1'b0, layer_q} + {{LAYER_W{1'b0}}, 1'b1};
   assign more_layers = layer_inc < {1'b0, nl_q};
   assign wd_inc      = wd_q + {{(TMO_W-1){1'b0}}, 1'b1};

   // Next-state logic: start/reject in IDLE; abort, advance or timeout in WAIT.
   always_comb begin
      logic       issue;
      logic [7:0] pulse8;
      state_d = state_q;
      mode_d  = mode_q;
      nl_d    = nl_q;
      tmo_d   = tmo_q;
      done_d  = done_q;
      err_d   = err_q;
      cur_d   = cur_q;
      layer_d = layer_q;
      wd_d    = wd_q;
      issue   = 1'b0;
      pulse8  = '0;
      stage_en_d = '0;
      case (state_q)
         ST_IDLE: begin
            if (en) begin
               if ((mode != '0) && (num_layers != '0)) begin
                  mode_d  = mode;
                  nl_d    = num_layers;
                  tmo_d   = tmo_limit;
                  done_d  = 1'b0;
                  err_d   = 1'b0;
                  layer_d = '0;
                  cur_d   = low_in;
                  wd_d    = '0;
                  issue   = 1'b1;
                  state_d = ST_WAIT;
               end else begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (abort) begin
               state_d = ST_IDLE;
               done_d  = 1'b0;
            end else if (accept) begin
               if (next_q[3]) begin
                  cur_d = next_q[2:0];
                  wd_d  = '0;
                  issue = 1'b1;
               end else if (more_layers) begin
                  layer_d = layer_inc[LAYER_W-1:0];
                  cur_d   = low_q;
                  wd_d    = '0;
                  issue   = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               wd_d = wd_inc;
               if ((tmo_q != '0) && (wd_inc == tmo_q)) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      pulse8 = 8'b0000_0001 << cur_d;
      if (issue) stage_en_d = pulse8[NUM_STAGES-1:0];
   end

   // State and datapath registers, cleared asynchronously by the active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         mode_q     <= '0;
         nl_q       <= '0;
         tmo_q      <= '0;
         stage_en_q <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         cur_q      <= '0;
         layer_q    <= '0;
         wd_q       <= '0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         nl_q       <= nl_d;
         tmo_q      <= tmo_d;
         stage_en_q <= stage_en_d;
         done_q     <= done_d;
         err_q      <= err_d;
         cur_q      <= cur_d;
         layer_q    <= layer_d;
         wd_q       <= wd_d;
      end
   end

   assign stage_en  = stage_en_q;
   assign busy      = (state_q == ST_WAIT);
   assign done      = done_q;
   assign err       = err_q;
   assign cur_stage = cur_q;
   assign layer_idx = layer_q;

endmodule

// File: tb/tb_cnn_seq_ctrl.sv
// Bench for cnn_seq_ctrl: directed scenarios, an automatic stage responder,
// and a monitor that matches every stage_en pulse against an expected queue.
module tb_cnn_seq_ctrl;

   localparam int NS = 4;
   localparam int LW = 4;
   localparam int TW = 16;
   localparam int EW = NS + LW + 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic          abort;
   logic [NS-1:0] mode;
   logic [LW-1:0] num_layers;
   logic [TW-1:0] tmo_limit;
   logic [NS-1:0] stage_done;
   logic [NS-1:0] stage_en;
   logic          busy;
   logic          done;
   logic          err;
   logic [2:0]    cur_stage;
   logic [LW-1:0] layer_idx;

   // responder controls
   logic [NS-1:0] stuck;
   logic [NS-1:0] resp_bits;
   bit            resp_on;
   int            resp_delay;
   int            pend_cnt;
   int            pend_idx;

   int n_checks = 0;
   int n_errors = 0;
   logic [EW-1:0] exp_q[$];

   cnn_seq_ctrl #(.NUM_STAGES(NS), .LAYER_W(LW), .TMO_W(TW)) dut (
      .clk(clk), .rst(rst_n), .en(en), .abort(abort), .mode(mode),
      .num_layers(num_layers), .tmo_limit(tmo_limit), .stage_done(stage_done),
      .stage_en(stage_en), .busy(busy), .done(done), .err(err),
      .cur_stage(cur_stage), .layer_idx(layer_idx)
   );

   // clock
   always #5 clk = ~clk;

   assign stage_done = stuck | resp_bits;

   // Expected pulse record: {stage_en, layer_idx, cur_stage}.
   function automatic logic [EW-1:0] mk(input int idx, input int lay);
      logic [NS-1:0] oh;
      oh = 4'b0001 << idx;
      return {oh, 4'(lay), 3'(idx)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Issue a start request for one cycle; returns on the first cycle after acceptance.
   task automatic start(input logic [NS-1:0] m, input logic [LW-1:0] nl, input logic [TW-1:0] tmo);
      @(negedge clk);
      mode       = m;
      num_layers = nl;
      tmo_limit  = tmo;
      en         = 1'b1;
      @(negedge clk);
      en = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      check(name, busy, 0);
   endtask

   task automatic wait_pulse(input string name, input logic [NS-1:0] pat, input logic [LW-1:0] lay,
                             input int budget);
      bit found;
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (stage_en == pat && layer_idx == lay) begin
            found = 1'b1;
            break;
         end
      end
      check(name, found, 1);
   endtask

   // Stage responder: raises the pulsed stage's done level resp_delay cycles after its pulse.
   always @(negedge clk) begin
      if (!rst_n) begin
         resp_bits = '0;
         pend_cnt  = 0;
      end else if (stage_en != '0) begin
         resp_bits = '0;
         for (int i = 0; i < NS; i++) if (stage_en[i]) pend_idx = i;
         pend_cnt = resp_on ? resp_delay : 0;
      end else if (pend_cnt > 0) begin
         pend_cnt--;
         if (pend_cnt == 0) resp_bits[pend_idx] = 1'b1;
      end
   end

   // Monitor: every stage_en pulse must match the head of the expected queue.
   always @(negedge clk) begin : mon
      logic [EW-1:0] e;
      if (rst_n && stage_en != '0) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_pulse: got stage_en=%b layer=%0d cur=%0d, none expected",
                     stage_en, layer_idx, cur_stage);
         end else begin
            e = exp_q.pop_front();
            if ({stage_en, layer_idx, cur_stage} !== e) begin
               n_errors++;
               $display("FAIL pulse: got {en,layer,cur}=%b_%0d_%0d expected %b_%0d_%0d",
                        stage_en, layer_idx, cur_stage, e[EW-1:LW+3], e[LW+2:3], e[2:0]);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; en = 1'b0; abort = 1'b0; mode = '0; num_layers = '0; tmo_limit = '0;
      stuck = '0; resp_on = 1'b1; resp_delay = 3; pend_idx = 0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_stage_en", stage_en, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_cur", cur_stage, 0);
      check("rst_layer", layer_idx, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // all four stages, one layer
      for (int i = 0; i < 4; i++) exp_q.push_back(mk(i, 0));
      resp_delay = 3;
      start(4'b1111, 4'd1, 16'd0);
      check("t1_busy", busy, 1);
      check("t1_done_clr", done, 0);
      wait_idle("t1_timeout", 200);
      check("t1_done", done, 1);
      check("t1_err", err, 0);
      check("t1_cur", cur_stage, 3);
      check("t1_q", exp_q.size(), 0);

      // sparse mask, two layers, ignored done bits and input changes during the run
      exp_q.push_back(mk(1, 0)); exp_q.push_back(mk(3, 0));
      exp_q.push_back(mk(1, 1)); exp_q.push_back(mk(3, 1));
      stuck = 4'b0101;
      resp_delay = 2;
      start(4'b1010, 4'd2, 16'd0);
      mode = 4'b0001; num_layers = 4'd5; tmo_limit = 16'd1;
      @(negedge clk); en = 1'b1;
      @(negedge clk); en = 1'b0;
      wait_idle("t2_timeout", 200);
      check("t2_done", done, 1);
      check("t2_err", err, 0);
      check("t2_layer", layer_idx, 1);
      check("t2_cur", cur_stage, 3);
      check("t2_q", exp_q.size(), 0);
      stuck = '0;

      // rejected starts: empty mask, zero layers; position holds
      start(4'b0000, 4'd2, 16'd0);
      check("rej0_done", done, 1);
      check("rej0_err", err, 1);
      check("rej0_busy", busy, 0);
      check("rej0_cur_hold", cur_stage, 3);
      check("rej0_layer_hold", layer_idx, 1);
      start(4'b0011, 4'd0, 16'd0);
      check("rej1_err", err, 1);
      check("rej1_busy", busy, 0);
      repeat (3) @(negedge clk);
      exp_q.push_back(mk(0, 0));
      resp_delay = 1;
      start(4'b0001, 4'd1, 16'd0);
      check("restart_done_clr", done, 0);
      check("restart_err_clr", err, 0);
      wait_idle("restart_timeout", 100);
      check("restart_done", done, 1);
      check("restart_err", err, 0);
      check("restart_q", exp_q.size(), 0);

      // stale done held high: next pulse exactly two cycles after the first
      stuck = 4'b0001;
      resp_delay = 2;
      exp_q.push_back(mk(0, 0)); exp_q.push_back(mk(1, 0));
      repeat (2) @(negedge clk);
      start(4'b0011, 4'd1, 16'd0);
      check("stale_p0", stage_en, 4'b0001);
      @(negedge clk);
      check("stale_gap", stage_en, 4'b0000);
      @(negedge clk);
      check("stale_p1", stage_en, 4'b0010);
      wait_idle("stale_timeout", 100);
      check("stale_done", done, 1);
      check("stale_q", exp_q.size(), 0);
      stuck = '0;

      // watchdog: stage never completes, limit 5
      begin
         int wcnt;
         resp_on = 1'b0;
         exp_q.push_back(mk(0, 0));
         start(4'b0001, 4'd1, 16'd5);
         wcnt = 0;
         for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            wcnt++;
            @(negedge clk);
         end
         check("tmo_cycles", wcnt, 5);
         check("tmo_err", err, 1);
         check("tmo_done", done, 1);
         repeat (5) @(negedge clk);
         check("tmo_no_pulse", stage_en, 0);
         check("tmo_q", exp_q.size(), 0);
         resp_on = 1'b1;
      end

      // abort during layer 1, stage 2
      resp_delay = 2;
      for (int l = 0; l < 2; l++) for (int s = 0; s < 3; s++) exp_q.push_back(mk(s, l));
      start(4'b0111, 4'd2, 16'd0);
      wait_pulse("abort_reach", 4'b0100, 4'd1, 300);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_stage_en", stage_en, 0);
      check("abort_done", done, 0);
      check("abort_err", err, 0);
      repeat (10) @(negedge clk);
      check("abort_idle", busy, 0);
      check("abort_q", exp_q.size(), 0);

      // reset mid-run
      resp_delay = 3;
      exp_q.push_back(mk(0, 0)); exp_q.push_back(mk(1, 0));
      start(4'b1111, 4'd1, 16'd0);
      wait_pulse("rstmid_reach", 4'b0010, 4'd0, 100);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_busy", busy, 0);
      check("rstmid_stage_en", stage_en, 0);
      check("rstmid_done", done, 0);
      check("rstmid_err", err, 0);
      check("rstmid_cur", cur_stage, 0);
      check("rstmid_layer", layer_idx, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("rstmid_idle", busy, 0);
      check("rstmid_q", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
